// File: rtl/bus_machine_timer.sv
// Memory-mapped machine timer (mtime/mtimecmp) acting as a request/ready bus responder.
// Prescaled 64-bit counter, 64-bit compare register and a registered level interrupt.
module bus_machine_timer #(
    parameter int FREQUENCY      = 10000000,
    parameter int TICK_FREQUENCY = 1000000
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_request,
    input  logic        i_rw,
    output logic        o_ready,
    input  logic [31:0] i_address,
    output logic [31:0] o_rdata,
    input  logic [31:0] i_wdata,
    input  logic [3:0]  i_wmask,
    output logic        o_interrupt
);

    localparam int PRESCALE = FREQUENCY / TICK_FREQUENCY;
    localparam int CW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    generate
        if (PRESCALE < 1) begin : g_bad_prescale
            $error("bus_machine_timer: FREQUENCY/TICK_FREQUENCY must be >= 1");
        end
    endgenerate

    localparam logic [1:0] ST_IDLE         = 2'd0;
    localparam logic [1:0] ST_ACK          = 2'd1;
    localparam logic [1:0] ST_WAIT_RELEASE = 2'd2;

    logic [1:0]    state;
    logic [63:0]   mtime;
    logic [63:0]   mtimecmp;
    logic [31:0]   shadow_hi;
    logic [1:0]    control;
    logic [CW-1:0] pcount;

    logic          access;
    logic          rd;
    logic          wr;
    logic [2:0]    sel;
    logic          mtime_wr;
    logic          tick;
    logic [31:0]   rd_value;
    logic          unused_addr;

    assign unused_addr = ^{i_address[31:5], i_address[1:0]};

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] mask);
        logic [31:0] r;
        r = old;
        for (int unsigned n = 0; n < 4; n++) begin
            if (mask[n]) r[8*n +: 8] = wd[8*n +: 8];
        end
        return r;
    endfunction

    always_comb begin
        access   = (state == ST_IDLE) && i_request;
        rd       = access && !i_rw;
        wr       = access && i_rw;
        sel      = i_address[4:2];
        // An all-zero mask is a no-op, so it must not restart the prescaler either.
        mtime_wr = wr && (sel == 3'd0 || sel == 3'd1) && (i_wmask != 4'b0000);
        tick     = control[0] && (pcount == CW'(PRESCALE - 1));
        rd_value = '0;
        case (sel)
            3'd0:    rd_value = mtime[31:0];
            3'd1:    rd_value = shadow_hi;
            3'd2:    rd_value = mtimecmp[31:0];
            3'd3:    rd_value = mtimecmp[63:32];
            3'd4:    rd_value = {30'b0, control};
            default: rd_value = '0;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state       <= ST_IDLE;
            o_ready     <= 1'b0;
            o_rdata     <= '0;
            o_interrupt <= 1'b0;
            mtime       <= '0;
            mtimecmp    <= '1;
            shadow_hi   <= '0;
            control     <= 2'b01;
            pcount      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_request) begin
                        o_ready <= 1'b1;
                        state   <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    o_ready <= 1'b0;
                    state   <= ST_WAIT_RELEASE;
                end
                ST_WAIT_RELEASE: begin
                    if (!i_request) state <= ST_IDLE;
                end
                default: begin
                    o_ready <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase

            if (rd) begin
                o_rdata <= rd_value;
                if (sel == 3'd0) shadow_hi <= mtime[63:32];
            end

            if (mtime_wr) begin
                pcount <= '0;
            end else if (control[0]) begin
                pcount <= tick ? '0 : pcount + 1'b1;
            end

            // A bus write to either half takes priority over a coincident tick.
            if (mtime_wr) begin
                if (sel == 3'd0) mtime[31:0]  <= merge(mtime[31:0], i_wdata, i_wmask);
                else             mtime[63:32] <= merge(mtime[63:32], i_wdata, i_wmask);
            end else if (tick) begin
                mtime <= mtime + 64'd1;
            end

            if (wr && sel == 3'd2) mtimecmp[31:0]  <= merge(mtimecmp[31:0], i_wdata, i_wmask);
            if (wr && sel == 3'd3) mtimecmp[63:32] <= merge(mtimecmp[63:32], i_wdata, i_wmask);
            if (wr && sel == 3'd4 && i_wmask[0]) control <= i_wdata[1:0];

            o_interrupt <= control[1] && (mtime >= mtimecmp);
        end
    end

endmodule
